// File: rtl/core_acc_drain_pkg.sv
// Shared definitions for the accumulator drain block: default widths and
// the helper that sizes the FIFO occupancy counter.
package core_acc_drain_pkg;

    localparam int IDATA_BIT_DEF   = 25;
    localparam int ODATA_BIT_DEF   = 8;
    localparam int SHIFT_WIDTH_DEF = 5;
    localparam int FIFO_DEPTH_DEF  = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Read/write pointer width; pointers wrap naturally for power-of-2 depths.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/core_acc_drain_fifo.sv
// Show-ahead FIFO for requantized results. The head entry is presented
// combinationally from storage; the read data is forced to zero when empty.
// A push is accepted when not full or when a pop happens on the same edge.
module core_acc_drain_fifo
    import core_acc_drain_pkg::*;
#(
    parameter int DATA_W = ODATA_BIT_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_cnt == CW'(0));
    assign w_full  = (r_cnt == CW'(DEPTH));
    // A pop on an empty FIFO is ignored.
    assign w_pop   = i_pop && !w_empty;
    // When full, the same-edge pop frees the slot the write lands in.
    assign w_push  = i_push && (!w_full || w_pop);

    // Storage write; contents are not reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Show-ahead head presentation, zero while empty.
    always_comb begin
        o_rd_data = {DATA_W{1'b0}};
        if (w_empty) begin
            o_rd_data = {DATA_W{1'b0}};
        end else begin
            o_rd_data = r_mem[r_rd_ptr];
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_cnt;

endmodule

// File: rtl/core_acc_drain.sv
// Accumulator drain: rounds, arithmetically shifts and saturates each
// accumulated sum (stage 1), then buffers results in a show-ahead FIFO for a
// consumer with ready/valid handshake. The source cannot be stalled, so a
// result arriving at a full FIFO without a same-cycle pop is dropped and
// flagged. Saturation and drop events are kept in sticky flags.
module core_acc_drain
    import core_acc_drain_pkg::*;
#(
    parameter int IDATA_BIT   = IDATA_BIT_DEF,
    parameter int ODATA_BIT   = ODATA_BIT_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [SHIFT_WIDTH-1:0]              cfg_shift,
    input  logic signed [IDATA_BIT-1:0]         idata,
    input  logic                                idata_valid,
    output logic signed [ODATA_BIT-1:0]         odata,
    output logic                                odata_valid,
    input  logic                                odata_ready,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    fifo_cnt,
    output logic                                sat_flag,
    output logic                                ovf_flag,
    input  logic                                err_clr
);

    localparam int EXT_W = IDATA_BIT + 1;
    localparam int CW    = cnt_width(FIFO_DEPTH);

    // Saturation bounds expressed in the extended working width.
    localparam logic signed [EXT_W-1:0] C_MAX =
        EXT_W'((64'sd1 <<< (ODATA_BIT - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] C_MIN = ~C_MAX;
    localparam logic [ODATA_BIT-1:0]    O_MAX = C_MAX[ODATA_BIT-1:0];
    localparam logic [ODATA_BIT-1:0]    O_MIN = C_MIN[ODATA_BIT-1:0];

    logic [EXT_W-1:0]        w_rnd;
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_q;
    logic [ODATA_BIT-1:0]    w_sat_val;
    logic                    w_clamp;

    logic                    r_s1_valid;
    logic [ODATA_BIT-1:0]    r_s1_data;
    logic                    r_s1_sat;
    logic                    r_sat_flag;
    logic                    r_ovf_flag;

    logic [ODATA_BIT-1:0]    w_fifo_data;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [CW-1:0]           w_fifo_cnt;
    logic                    w_pop;
    logic                    w_drop;

    // Round-half-up offset: half an output LSB, none when not shifting.
    always_comb begin
        w_rnd = {EXT_W{1'b0}};
        if (cfg_shift != {SHIFT_WIDTH{1'b0}}) begin
            w_rnd = EXT_W'(1) << (cfg_shift - SHIFT_WIDTH'(1));
        end else begin
            w_rnd = {EXT_W{1'b0}};
        end
    end

    // One guard bit above the input keeps the rounding add from wrapping.
    assign w_ext = {idata[IDATA_BIT-1], idata};
    assign w_sum = w_ext + $signed(w_rnd);
    assign w_q   = w_sum >>> cfg_shift;

    // Clamp the shifted value into the signed output range.
    always_comb begin
        w_sat_val = w_q[ODATA_BIT-1:0];
        w_clamp   = 1'b0;
        if (w_q > C_MAX) begin
            w_sat_val = O_MAX;
            w_clamp   = 1'b1;
        end else if (w_q < C_MIN) begin
            w_sat_val = O_MIN;
            w_clamp   = 1'b1;
        end else begin
            w_sat_val = w_q[ODATA_BIT-1:0];
            w_clamp   = 1'b0;
        end
    end

    // Stage-1 register: result captured on the input pulse, valid follows it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {ODATA_BIT{1'b0}};
            r_s1_sat   <= 1'b0;
        end else begin
            r_s1_valid <= idata_valid;
            r_s1_sat   <= idata_valid && w_clamp;
            if (idata_valid) begin
                r_s1_data <= w_sat_val;
            end
        end
    end

    assign w_pop  = odata_valid && odata_ready;
    // Result lost: FIFO full and no slot freed on this edge.
    assign w_drop = r_s1_valid && w_fifo_full && !w_pop;

    // Sticky error flags; a set on the same edge wins over a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_flag <= 1'b0;
            r_ovf_flag <= 1'b0;
        end else begin
            if (r_s1_sat) begin
                r_sat_flag <= 1'b1;
            end else if (err_clr) begin
                r_sat_flag <= 1'b0;
            end
            if (w_drop) begin
                r_ovf_flag <= 1'b1;
            end else if (err_clr) begin
                r_ovf_flag <= 1'b0;
            end
        end
    end

    core_acc_drain_fifo #(
        .DATA_W (ODATA_BIT),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_push    (r_s1_valid),
        .i_wr_data (r_s1_data),
        .i_pop     (odata_ready),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_cnt)
    );

    assign odata       = $signed(w_fifo_data);
    assign odata_valid = !w_fifo_empty;
    assign fifo_cnt    = w_fifo_cnt;
    assign sat_flag    = r_sat_flag;
    assign ovf_flag    = r_ovf_flag;

endmodule

// File: tb/tb_core_acc_drain.sv
// Self-checking bench for core_acc_drain: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a queue-based model.
module tb_core_acc_drain;

    localparam int IW = 25;
    localparam int OW = 8;
    localparam int SW = 5;
    localparam int D  = 4;
    localparam int CW = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [SW-1:0]        cfg_shift;
    logic signed [IW-1:0] idata;
    logic                 idata_valid;
    logic signed [OW-1:0] odata;
    logic                 odata_valid;
    logic                 odata_ready;
    logic [CW-1:0]        fifo_cnt;
    logic                 sat_flag;
    logic                 ovf_flag;
    logic                 err_clr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int shift;
        int din;
        int exp_q;
        bit exp_sat;
    } vec_t;

    vec_t vecs [12];

    core_acc_drain #(
        .IDATA_BIT   (IW),
        .ODATA_BIT   (OW),
        .SHIFT_WIDTH (SW),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_shift   (cfg_shift),
        .idata       (idata),
        .idata_valid (idata_valid),
        .odata       (odata),
        .odata_valid (odata_valid),
        .odata_ready (odata_ready),
        .fifo_cnt    (fifo_cnt),
        .sat_flag    (sat_flag),
        .ovf_flag    (ovf_flag),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference requantization straight from the arithmetic rule.
    function automatic void requant(input int v, input int s, output int q, output bit sat);
        longint t;
        t = v;
        if (s != 0) t = t + (64'sd1 <<< (s - 1));
        t = t >>> s;
        sat = 1'b0;
        if (t > 127) begin
            t = 127;
            sat = 1'b1;
        end else if (t < -128) begin
            t = -128;
            sat = 1'b1;
        end
        q = int'(t);
    endfunction

    task automatic pulse(input int v, input int s);
        cfg_shift   = SW'(s);
        idata       = IW'(v);
        idata_valid = 1'b1;
        step();
        idata_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #3;
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    initial begin
        int   mq[$];
        bit   m_pv;
        int   m_pq;
        bit   m_psat;
        bit   m_sat;
        bit   m_ovf;
        int   q;
        bit   s;

        rstn        = 1'b0;
        cfg_shift   = '0;
        idata       = '0;
        idata_valid = 1'b0;
        odata_ready = 1'b0;
        err_clr     = 1'b0;

        vecs[0]  = '{4, 100, 6, 1'b0};
        vecs[1]  = '{0, 300, 127, 1'b1};
        vecs[2]  = '{0, -300, -128, 1'b1};
        vecs[3]  = '{1, -3, -1, 1'b0};
        vecs[4]  = '{1, 3, 2, 1'b0};
        vecs[5]  = '{2, 16, 4, 1'b0};
        vecs[6]  = '{3, -12, -1, 1'b0};
        vecs[7]  = '{2, -6, -1, 1'b0};
        vecs[8]  = '{5, -16, 0, 1'b0};
        vecs[9]  = '{0, 127, 127, 1'b0};
        vecs[10] = '{0, -128, -128, 1'b0};
        vecs[11] = '{7, 32767, 127, 1'b1};

        // Reset state
        #12;
        chk("rst_valid", odata_valid, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_odata", odata, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_ovf", ovf_flag, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Directed vectors: latency, value, saturation, single-cycle valid
        odata_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            chk("clr_sat", sat_flag, 0);
            pulse(vecs[i].din, vecs[i].shift);
            chk("lat1_valid", odata_valid, 0);
            step();
            chk("lat2_valid", odata_valid, 1);
            chk("vec_odata", odata, vecs[i].exp_q);
            chk("vec_sat", sat_flag, vecs[i].exp_sat);
            step();
            chk("post_pop_valid", odata_valid, 0);
        end

        // Overflow: five results into a four-deep FIFO with no consumer
        err_clr = 1'b1;
        step();
        err_clr     = 1'b0;
        odata_ready = 1'b0;
        for (int k = 1; k <= 5; k++) pulse(k, 0);
        step();
        step();
        chk("ovf_cnt", fifo_cnt, 4);
        chk("ovf_flag", ovf_flag, 1);
        odata_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain", odata, k);
            step();
        end
        chk("ovf_empty", odata_valid, 0);
        chk("ovf_sticky", ovf_flag, 1);
        chk("empty_odata", odata, 0);
        step();
        chk("ready_empty_cnt", fifo_cnt, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", ovf_flag, 0);

        // Full FIFO with simultaneous push and pop
        odata_ready = 1'b0;
        for (int k = 10; k <= 13; k++) pulse(k, 0);
        step();
        step();
        chk("full_cnt", fifo_cnt, 4);
        pulse(20, 0);
        odata_ready = 1'b1;
        step();
        odata_ready = 1'b0;
        chk("pp_cnt", fifo_cnt, 4);
        chk("pp_ovf", ovf_flag, 0);
        chk("pp_head", odata, 11);
        odata_ready = 1'b1;
        begin
            int exp_order[4];
            exp_order = '{11, 12, 13, 20};
            for (int k = 0; k < 4; k++) begin
                chk("pp_drain", odata, exp_order[k]);
                step();
            end
        end
        chk("pp_empty", fifo_cnt, 0);

        // Reset mid-operation
        odata_ready = 1'b0;
        for (int k = 7; k <= 9; k++) pulse(k, 0);
        step();
        step();
        chk("mid_cnt", fifo_cnt, 3);
        pulse(55, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", odata_valid, 0);
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_odata", odata, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("inflight_gone", fifo_cnt, 0);
        pulse(16, 2);
        chk("mid_lat1", odata_valid, 0);
        step();
        chk("mid_lat2", odata_valid, 1);
        chk("mid_odata", odata, 4);
        chk("mid_cnt1", fifo_cnt, 1);

        // Randomized run against the queue model
        do_reset();
        mq.delete();
        m_pv  = 1'b0;
        m_pq  = 0;
        m_psat = 1'b0;
        m_sat = 1'b0;
        m_ovf = 1'b0;
        for (int n = 0; n < 500; n++) begin
            bit iv;
            bit rdy;
            bit ec;
            bit pop;
            bit drop;
            int sh;
            int val;
            iv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 99) < ((n < 250) ? 30 : 80));
            ec  = ($urandom_range(0, 19) == 0);
            sh  = int'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                val = int'($urandom_range(0, 32'h01FF_FFFF)) - 32'sh0100_0000;
            else
                val = int'($urandom_range(0, 20000)) - 10000;

            cfg_shift   = SW'(sh);
            idata       = IW'(val);
            idata_valid = iv;
            odata_ready = rdy;
            err_clr     = ec;

            pop  = rdy && (mq.size() > 0);
            drop = m_pv && (mq.size() >= D) && !pop;
            if (m_pv && m_psat) m_sat = 1'b1;
            else if (ec)        m_sat = 1'b0;
            if (drop)           m_ovf = 1'b1;
            else if (ec)        m_ovf = 1'b0;
            if (pop) void'(mq.pop_front());
            if (m_pv && !drop) mq.push_back(m_pq);
            m_pv = iv;
            if (iv) begin
                requant(val, sh, q, s);
                m_pq   = q;
                m_psat = s;
            end else begin
                m_psat = 1'b0;
            end

            step();
            chk("rnd_cnt", fifo_cnt, mq.size());
            chk("rnd_valid", odata_valid, (mq.size() > 0) ? 1 : 0);
            chk("rnd_odata", odata, (mq.size() > 0) ? mq[0] : 0);
            chk("rnd_sat", sat_flag, m_sat);
            chk("rnd_ovf", ovf_flag, m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_acc_drain.md
CORE_ACC_DRAIN -- requirements
Module: core_acc_drain

Interface
REQ-001 SHALL have parameter IDATA_BIT, default 25, signed accumulator result width.
REQ-002 SHALL have parameter ODATA_BIT, default 8, signed requantized output width.
REQ-003 SHALL have parameter SHIFT_WIDTH, default 5, width of the right-shift configuration.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-005 SHALL have one clock and asynchronous active-low reset: clk input 1 system clock; rstn input 1 async active-low reset.
REQ-006 SHALL have cfg_shift, input, SHIFT_WIDTH: arithmetic right-shift amount applied to each result.
REQ-007 SHALL have idata, input, IDATA_BIT: signed accumulated sum from the accumulator.
REQ-008 SHALL have idata_valid, input, 1: single-cycle pulse; no backpressure is possible toward the source.
REQ-009 SHALL have odata, output, ODATA_BIT: signed requantized value at FIFO head.
REQ-010 SHALL have odata_valid, output, 1: FIFO non-empty.
REQ-011 SHALL have odata_ready, input, 1: consumer accepts the head when high with odata_valid.
REQ-012 SHALL have fifo_cnt, output, $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-013 SHALL have sat_flag, output, 1: sticky, set when any result saturated.
REQ-014 SHALL have ovf_flag, output, 1: sticky, set when a result was dropped on full FIFO.
REQ-015 SHALL have err_clr, input, 1: synchronous clear of sat_flag and ovf_flag.

Function
REQ-016 Stage 1 SHALL register, on idata_valid, q = (idata + (cfg_shift!=0 ? 2^(cfg_shift-1) : 0)) >>> cfg_shift, computed in IDATA_BIT+1 signed bits (round half up, arithmetic shift).
REQ-017 Stage 1 SHALL saturate q to [-2^(ODATA_BIT-1), 2^(ODATA_BIT-1)-1] and assert a one-cycle sat indication when clamping occurs.
REQ-018 Stage 1 valid SHALL equal idata_valid delayed one cycle; cfg_shift SHALL be sampled in the same cycle as idata_valid.
REQ-019 A stage-1 valid result SHALL be written into the FIFO on the following edge; latency idata_valid -> odata_valid SHALL be 2 cycles when the FIFO is empty.
REQ-020 FIFO SHALL be show-ahead: odata reflects the head entry whenever odata_valid=1; odata SHALL be 0 when empty.
REQ-021 A pop SHALL occur on a rising edge with odata_valid && odata_ready; order SHALL be strictly FIFO.
REQ-022 Simultaneous push and pop SHALL be allowed at any occupancy, including full (count unchanged, write accepted).
REQ-023 Push to a full FIFO without a same-cycle pop SHALL drop the result, leave contents unchanged, and set ovf_flag.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt SHALL range 0..FIFO_DEPTH.
REQ-025 sat_flag/ovf_flag SHALL set one cycle after the causing event; err_clr SHALL clear them, with a same-cycle set event taking priority over err_clr.
REQ-026 odata_ready while empty SHALL have no effect.

Reset
REQ-027 On rstn low, stage-1 registers, FIFO pointers and fifo_cnt SHALL reset to 0; odata_valid=0, odata=0, sat_flag=0, ovf_flag=0, asynchronously.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight results; FIFO storage contents need not be reset.

Structure
REQ-029 ODATA_BIT/SHIFT_WIDTH defaults and the occupancy-width function SHALL live in the shared core package.
REQ-030 FIFO SHALL be a sub-module core_acc_drain_fifo (show-ahead, push/pop, full/empty/count); requantization SHALL stay in the top.

Verification
REQ-031 cfg_shift=4, idata=100 pulse, odata_ready=1 -> odata=6, odata_valid high exactly 2 cycles later for 1 cycle.
REQ-032 cfg_shift=0, idata=300 -> odata=127, sat_flag=1; idata=-300 -> odata=-128; err_clr -> sat_flag=0.
REQ-033 cfg_shift=1, idata=-3 -> odata=-1 (round half up); idata=3 -> odata=2.
REQ-034 odata_ready=0, 5 pulses values 1..5 (shift 0), FIFO_DEPTH=4 -> fifo_cnt=4, ovf_flag=1; drain yields 1,2,3,4.
REQ-035 FIFO full, odata_ready=1 and new push same cycle -> fifo_cnt stays 4, no ovf, new value appears last.
REQ-036 rstn low while fifo_cnt=3 -> odata_valid=0, fifo_cnt=0 immediately; next pulse idata=16, shift 2 -> odata=4 after 2 cycles.
